// File: rtl/uart_tx_sched.sv
// uart_tx_sched: two-requester round-robin scheduler in front of one 8N1
// serial transmitter. Bit timing comes from an external single-cycle baud
// tick; the block owns arbitration, framing and the per-bit hold.
module uart_tx_sched #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              baud_tick,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ack,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ack,
  output logic              tx,
  output logic              busy,
  output logic              grant_id
);

  // Counter must hold DATA_W-1 and STOP_BITS-1 without wrapping in a frame.
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] LAST_DATA_CNT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_STOP_CNT = CNT_W'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]        state_q,      state_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic [DATA_W-1:0] shift_q,      shift_d;
  logic              tx_q,         tx_d;
  logic              busy_q,       busy_d;
  logic              grant_id_q,   grant_id_d;
  logic              last_grant_q, last_grant_d;

  logic              winner_c;
  logic              accept_c;

  // Round-robin pick: the sole requester, or on a tie the one not served last.
  always_comb begin
    winner_c = 1'b0;
    if (req0_valid && req1_valid) begin
      winner_c = ~last_grant_q;
    end else if (req1_valid) begin
      winner_c = 1'b1;
    end
    accept_c = (state_q == S_IDLE) && (req0_valid || req1_valid);
  end

  // Acks are a direct decode of the accept so the requester sees them in the
  // same cycle its data is sampled.
  assign req0_ack = accept_c && !winner_c;
  assign req1_ack = accept_c &&  winner_c;

  // Next-state, datapath and line-level decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    busy_d       = busy_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    tx_d         = 1'b1;

    case (state_q)
      S_IDLE: begin
        // baud_tick is deliberately ignored here.
        if (accept_c) begin
          shift_d      = winner_c ? req1_data : req0_data;
          grant_id_d   = winner_c;
          last_grant_d = winner_c;
          busy_d       = 1'b1;
          cnt_d        = '0;
          state_d      = S_ALIGN;
        end
      end

      S_ALIGN: begin
        // Wait for a fresh tick so the start bit lasts a full period.
        if (baud_tick) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (baud_tick) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (cnt_q == LAST_DATA_CNT) begin
            cnt_d   = '0;
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_STOP: begin
        if (baud_tick) begin
          if (cnt_q == LAST_STOP_CNT) begin
            cnt_d   = '0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Line level follows the state being entered so tx lines up with it.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset drops any frame in flight.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed steps, a frame scoreboard fed when
// requests are driven and drained by a line monitor decoding tx.
module tb_uart_tx_sched;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       baud_tick  = 1'b0;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data  = '0;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data  = '0;
  logic       req0_ack, req1_ack, tx, busy, grant_id;

  // Second instance with two stop bits.
  logic       s2_req0_valid = 1'b0;
  logic [7:0] s2_req0_data  = '0;
  logic       s2_req1_valid = 1'b0;
  logic [7:0] s2_req1_data  = '0;
  logic       s2_req0_ack, s2_req1_ack, s2_tx, s2_busy, s2_grant_id;

  int tests = 0;
  int fails = 0;
  int ack0_cnt = 0;
  int ack1_cnt = 0;
  longint cyc = 0;
  int tick_div = 0;

  logic [8:0] exp_q[$];

  uart_tx_sched #(.DATA_W(8), .STOP_BITS(1)) u_dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .baud_tick(baud_tick),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ack(req0_ack),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ack(req1_ack),
    .tx(tx), .busy(busy), .grant_id(grant_id)
  );

  uart_tx_sched #(.DATA_W(8), .STOP_BITS(2)) u_dut_s2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .baud_tick(baud_tick),
    .req0_valid(s2_req0_valid), .req0_data(s2_req0_data), .req0_ack(s2_req0_ack),
    .req1_valid(s2_req1_valid), .req1_data(s2_req1_data), .req1_ack(s2_req1_ack),
    .tx(s2_tx), .busy(s2_busy), .grant_id(s2_grant_id)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Free-running baud tick, one cycle in sixteen.
  always @(negedge clk) begin
    tick_div  = (tick_div == 15) ? 0 : tick_div + 1;
    baud_tick = (tick_div == 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ack rules: never both, never while busy.
  always @(negedge clk) begin
    #1;
    if (req0_ack || req1_ack) begin
      check("ack_exclusive", 32'(req0_ack & req1_ack), 32'd0);
      check("ack_not_busy", 32'(busy), 32'd0);
    end
    if (req0_ack) ack0_cnt++;
    if (req1_ack) ack1_cnt++;
  end

  // Line monitor: a frame is 160 cycles from the falling edge; each bit is
  // latched on its first cycle and must hold for all 16.
  bit         mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [9:0] mon_bits;
  logic       mon_gid;
  bit         mon_glitch;

  always @(negedge clk) begin
    if (!rst_n) begin
      if (mon_active && exp_q.size() > 0) void'(exp_q.pop_front());
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active  = 1'b1;
        mon_cnt     = 0;
        mon_bits    = '0;
        mon_bits[0] = tx;
        mon_gid     = grant_id;
        mon_glitch  = 1'b0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt < 160) begin
        if (mon_cnt % 16 == 0) mon_bits[mon_cnt / 16] = tx;
        else if (tx !== mon_bits[mon_cnt / 16]) mon_glitch = 1'b1;
        if (mon_cnt == 159) check("busy_before_last_tick", 32'(busy), 32'd1);
      end else begin
        logic [8:0] e;
        logic [9:0] ef;
        check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e  = exp_q.pop_front();
          ef = {1'b1, e[7:0], 1'b0};
          check("frame_bits", 32'(mon_bits), 32'(ef));
          check("frame_grant", 32'(mon_gid), 32'(e[8]));
        end
        check("frame_bit_width", 32'(mon_glitch), 32'd0);
        check("busy_after_tenth_tick", 32'(busy), 32'd0);
        mon_active = 1'b0;
      end
    end
  end

  // Drive one request and hold it until acked; called with no other request.
  task automatic send(input bit id, input logic [7:0] d);
    bit got = 1'b0;
    @(negedge clk);
    if (id) begin req1_valid = 1'b1; req1_data = d; end
    else    begin req0_valid = 1'b1; req0_data = d; end
    exp_q.push_back({id, d});
    for (int i = 0; i < 4000 && !got; i++) begin
      #1;
      if (id ? req1_ack : req0_ack) got = 1'b1;
      else @(negedge clk);
    end
    check("send_ack_seen", 32'(got), 32'd1);
    @(negedge clk);
    #1;
    check("ack_one_cycle", 32'(id ? req1_ack : req0_ack), 32'd0);
    check("busy_after_accept", 32'(busy), 32'd1);
    check("grant_after_accept", 32'(grant_id), 32'(id));
    check("tx_high_in_align", 32'(tx), 32'd1);
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  // Wait (just after a negedge) for either ack.
  task automatic wait_any_ack(output bit id, output bit ok);
    id = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      #1;
      if (req0_ack || req1_ack) begin
        id = req1_ack;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("ack_within_bound", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      #2;
      if (!busy && !mon_active && exp_q.size() == 0) done = 1'b1;
    end
    check("idle_within_bound", 32'(done), 32'd1);
  endtask

  initial begin
    logic [7:0] vals[6];
    logic [7:0] b2b[3];
    bit         gid, ok, found;
    longint     last_ack_cyc;
    int         a1, lo, hi;

    #20000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] vals[6];
    logic [7:0] b2b[3];
    bit         gid, ok, found;
    longint     last_ack_cyc;
    int         a1, lo, hi;

    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    b2b  = '{8'h3C, 8'hC3, 8'h5A};
    last_ack_cyc = 0;

    // Reset values.
    repeat (3) @(negedge clk);
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_ack0", 32'(req0_ack), 32'd0);
    check("rst_ack1", 32'(req1_ack), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Tie from reset: req0 first, then strict alternation over refills.
    @(negedge clk);
    req0_valid = 1'b1; req0_data = vals[0];
    req1_valid = 1'b1; req1_data = vals[1];
    exp_q.push_back({1'b0, vals[0]});
    exp_q.push_back({1'b1, vals[1]});
    for (int k = 0; k < 6; k++) begin
      wait_any_ack(gid, ok);
      if (!ok) break;
      check("tie_grant_order", 32'(gid), 32'(k % 2));
      @(negedge clk);
      if (k + 2 < 6) begin
        if (gid) req1_data = vals[k + 2]; else req0_data = vals[k + 2];
        exp_q.push_back({gid, vals[k + 2]});
      end else begin
        if (gid) req1_valid = 1'b0; else req0_valid = 1'b0;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();

    // Single byte on req0.
    send(1'b0, 8'hA5);
    wait_idle();

    // Back-to-back frames from req1 alone.
    @(negedge clk);
    req1_valid = 1'b1; req1_data = b2b[0];
    exp_q.push_back({1'b1, b2b[0]});
    for (int k = 0; k < 3; k++) begin
      wait_any_ack(gid, ok);
      if (!ok) break;
      check("b2b_grant", 32'(gid), 32'd1);
      if (k > 0) check("b2b_gap_le_one_period",
                       32'((cyc - last_ack_cyc) >= 161 && (cyc - last_ack_cyc) <= 176), 32'd1);
      last_ack_cyc = cyc;
      @(negedge clk);
      if (k < 2) begin
        req1_data = b2b[k + 1];
        exp_q.push_back({1'b1, b2b[k + 1]});
      end else begin
        req1_valid = 1'b0;
      end
    end
    req1_valid = 1'b0;
    wait_idle();

    // Withdrawn request: one-cycle req1 pulse while busy is never served.
    send(1'b0, 8'h77);
    repeat (20) @(negedge clk);
    a1 = ack1_cnt;
    req1_valid = 1'b1; req1_data = 8'h99;
    @(negedge clk);
    req1_valid = 1'b0;
    wait_idle();
    repeat (400) @(negedge clk);
    #2;
    check("withdraw_no_ack", 32'(ack1_cnt), 32'(a1));
    check("withdraw_no_frame", 32'(busy | mon_active), 32'd0);

    // Reset during data bit 3 after a req0 grant.
    send(1'b0, 8'hE7);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      #2;
      if (mon_active && mon_cnt == 72) found = 1'b1;
    end
    check("reach_data_bit3", 32'(found), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_grant", 32'(grant_id), 32'd0);
    @(negedge clk);
    #1;
    check("midrst_frame_dropped", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'h12;
    req1_valid = 1'b1; req1_data = 8'h34;
    exp_q.push_back({1'b0, 8'h12});
    exp_q.push_back({1'b1, 8'h34});
    for (int k = 0; k < 2; k++) begin
      wait_any_ack(gid, ok);
      if (!ok) break;
      check("postrst_grant_order", 32'(gid), 32'(k));
      @(negedge clk);
      if (gid) req1_valid = 1'b0; else req0_valid = 1'b0;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();

    // Two stop bits, data 0xFF: 16 cycles low, then 160 high until busy drops.
    @(negedge clk);
    s2_req0_valid = 1'b1; s2_req0_data = 8'hFF;
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      #1;
      if (s2_req0_ack) ok = 1'b1;
      else @(negedge clk);
    end
    check("s2_ack_seen", 32'(ok), 32'd1);
    @(negedge clk);
    s2_req0_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (s2_tx === 1'b0) found = 1'b1;
      else @(negedge clk);
    end
    check("s2_start_seen", 32'(found), 32'd1);
    lo = 0;
    while (s2_tx === 1'b0 && lo < 1000) begin
      lo++;
      @(negedge clk);
    end
    hi = 0;
    while (s2_busy === 1'b1 && s2_tx === 1'b1 && hi < 1000) begin
      hi++;
      @(negedge clk);
    end
    check("s2_start_cycles", 32'(lo), 32'd16);
    check("s2_high_cycles_before_idle", 32'(hi), 32'd160);
    check("s2_busy_dropped", 32'(s2_busy), 32'd0);
    check("s2_tx_idle", 32'(s2_tx), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Shares one 8N1 serial transmit line between two byte requesters.
- Arbitration is round-robin.
- Each frame is paced by the single-cycle baud tick from the system baud generator: 200 MHz sys_clk, ~115200 tick rate.
- Sits between the host-side byte sources (command responder, status streamer) and the USB-UART bridge TX pin.
- Owns arbitration, framing and bit timing. The baud generator itself stays a free-running accumulator.

Parameters:
DATA_W, 8, payload bits per frame, sent LSB first.
STOP_BITS, 1, stop-bit periods per frame; legal values 1 or 2.

Ports:
sys_clk  input  1  system clock, 200 MHz.
sys_rst_n  input  1  reset, asynchronous assert, active-low.
baud_tick  input  1  one-cycle pulse, one per bit period, from the baud generator.
req0_valid  input  1  requester 0 has a byte pending.
req0_data  input  DATA_W  requester 0 byte.
req0_ack  output  1  one-cycle pulse: requester 0 byte accepted.
req1_valid  input  1  requester 1 has a byte pending.
req1_data  input  DATA_W  requester 1 byte.
req1_ack  output  1  one-cycle pulse: requester 1 byte accepted.
tx  output  1  serial line; idle high; registered.
busy  output  1  high from accept cycle until frame end.
grant_id  output  1  requester whose frame is in flight; valid while busy.

Behaviour:
- Reset (async, sys_rst_n=0): tx=1, busy=0, grant_id=0, req0_ack=0, req1_ack=0. State=IDLE, bit counter=0, last_grant=1, so req0 wins the first tie. Reset mid-frame drops the frame; tx returns high immediately and no ack is reissued.
- Handshake:
  - A requester holds valid and data stable until it sees its ack.
  - Data is sampled only in the accept cycle.
  - Deasserting valid before ack is permitted and simply withdraws the request.
- States: IDLE, ALIGN, START, DATA, STOP.
- IDLE:
  - If any valid is high, accept in this cycle. Winner is the sole requester, or on a tie the one != last_grant.
  - In the accept cycle: winner's ack=1 (combinational decode of the accept), shift register <= winner data, grant_id <= winner, last_grant <= winner, busy <= 1, next state ALIGN.
  - baud_tick is ignored in IDLE.
- ALIGN: tx=1. On baud_tick go to START. This aligns the start bit to a full bit period; a tick coincident with the accept cycle is not used.
- START: tx=0 (registered, so the pin falls one cycle after the aligning tick). On baud_tick go to DATA with bit counter=0.
- DATA:
  - tx = shift_reg[0].
  - On baud_tick: shift right, counter+1. When the counter reaches DATA_W-1 on a tick, go to STOP with counter=0.
- STOP:
  - tx=1.
  - On baud_tick: counter+1. After STOP_BITS ticks go to IDLE with busy <= 0.
  - The next accept can occur in the first IDLE cycle, so back-to-back frames carry one extra idle bit period at most (ALIGN).
- Frame length: exactly 1 + DATA_W + STOP_BITS tick periods from the tx falling edge to the first cycle in which tx may fall again. ALIGN adds 0..1 period before each start bit.
- Acks: exactly one ack per frame, never both in one cycle, never while busy.
- Fairness: with both valid continuously, grants alternate 0,1,0,1…
- Counter width: ceil(log2(DATA_W+1)); it must not wrap inside a frame.
- A baud_tick held high for more than one cycle is outside the contract. Each high cycle counts as a tick.

Test Plan:
- Single byte: req0_valid with req0_data=8'hA5, tick every 16 cycles. Expect:
  - req0_ack for 1 cycle.
  - tx=1 until the first tick after accept, then 0.
  - Then bits 1,0,1,0,0,1,0,1 each exactly 16 cycles.
  - Then stop=1.
  - busy falls on the 10th tick after the start tick.
- Tie arbitration: both valid from reset, req0=8'h11, req1=8'h22, held until ack. Expect frames 8'h11 then 8'h22; grant_id 0 then 1; acks alternate across 4 more refills.
- Back-to-back same requester: req1 valid continuously with req0 idle. Expect consecutive frames granted to req1, with gap ≤ 1 bit period, and no ack while busy.
- STOP_BITS=2, data 8'hFF. Expect tx low for exactly one period (start), then high for 10 periods before busy drops.
- Reset mid-frame: assert sys_rst_n=0 during DATA bit 3. Expect tx=1 and busy=0 asynchronously. After release, a pending tie is granted to req0 first.
- Withdrawn request: req1_valid pulses for 1 cycle while busy. Expect no req1_ack, and no frame for req1 after the current one.
